// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared encodings for the fetch/data memory port arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Width of both the latency counter and the data-streak counter.
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter : one memory port shared by fetch and data requests |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        if_valid,
  output logic        d_valid,
  output logic [31:0] rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] streak_q, streak_d;

  logic fetch_ok;
  logic fetch_first;
  logic grant_if;
  logic grant_d;
  logic done;

  // Data normally wins; a full streak hands one grant to a waiting fetch.
  assign fetch_ok    = if_req & ~if_kill;
  assign fetch_first = fetch_ok & (streak_q == STREAK_MAX);
  assign grant_d     = (state_q == IDLE) & d_req & ~fetch_first;
  assign grant_if    = (state_q == IDLE) & (fetch_first | (fetch_ok & ~d_req));
  assign done        = (state_q == WAIT) & (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (if_req) begin
            streak_d = streak_q + 1'b1;
          end
          state_d = ISSUE;
        end else if (grant_if) begin
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
        if ((owner_q == OWN_IF) && if_kill) begin
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (done) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else if ((owner_q == OWN_IF) && if_kill) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are gated by reset so nothing leaks out while it is asserted.
  assign mem_en    = reset & (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = mem_rdata;

  assign if_valid = reset & done & (owner_q == OWN_IF) & ~kill_q & ~if_kill;
  assign d_valid  = reset & done & (owner_q == OWN_D);

  assign stall_f = if_req & ~if_valid & ~if_kill;
  assign stall_m = d_req & ~d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : two arbiters (LAT 2 and LAT 1) vs timeline model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int MS0  = 4;
  localparam int LAT1 = 1;
  localparam int MS1  = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  if_req, if_kill, d_req, d_we;
  logic [31:0] if_addr [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [1:0]  if_valid, d_valid, stall_f, stall_m, mem_en, mem_we;
  logic [31:0] rdata     [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int nchk = 0;
  int nerr = 0;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {8'hA5, i, ~i, i ^ 8'h3C};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int ms_of(input int k);
    return (k == 0) ? MS0 : MS1;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L  = (g == 0) ? LAT0 : LAT1;
    localparam int MS = (g == 0) ? MS0 : MS1;

    mem_port_arbiter #(.LAT(L), .MAX_STREAK(MS)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_kill   (if_kill[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .if_valid  (if_valid[g]),
      .d_valid   (d_valid[g]),
      .rdata     (rdata[g]),
      .stall_f   (stall_f[g]),
      .stall_m   (stall_m[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Memory device: read data appears L cycles after the strobe cycle.
    logic [31:0] dmem [256];
    logic [7:0]  ridx = 8'd0;
    int          rcnt = 0;
    initial for (int i = 0; i < 256; i++) dmem[i] = init_word(8'(i));
    always @(posedge clk) begin
      if (rcnt > 0) rcnt <= rcnt - 1;
      if (mem_en[g]) begin
        if (mem_we[g]) dmem[mem_addr[g][9:2]] <= mem_wdata[g];
        ridx <= mem_addr[g][9:2];
        rcnt <= L;
      end
    end
    assign mem_rdata[g] = (rcnt == 1) ? dmem[ridx] : 32'h0BAD_F00D;
  end

  // Transaction-timeline reference model, one slot per instance.
  bit          m_busy [2];
  bit          m_own_d[2];
  bit          m_kill [2];
  bit          m_we   [2];
  bit          m_wdk  [2];
  int          m_age  [2];
  int          m_strk [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] mmem   [2][256];

  bit          seen_ifv[2], seen_dv[2], last_ifdone[2], last_ddone[2];
  logic [31:0] seen_rdata[2];
  int          en_seen[2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] at %0t: observed %h expected %h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit e_en, e_done, e_ifv, e_dv, e_rd, fok, take_f;
      e_en   = reset && m_busy[k] && (m_age[k] == 1);
      e_done = reset && m_busy[k] && (m_age[k] == lat_of(k) + 1);
      e_ifv  = e_done && !m_own_d[k] && !m_kill[k] && !if_kill[k];
      e_dv   = e_done && m_own_d[k];
      e_rd   = e_ifv || (e_dv && !m_we[k]);
      chk("mem_en",   k, 32'(mem_en[k]),   32'(e_en));
      chk("mem_we",   k, 32'(mem_we[k]),   32'(e_en && m_we[k]));
      chk("if_valid", k, 32'(if_valid[k]), 32'(e_ifv));
      chk("d_valid",  k, 32'(d_valid[k]),  32'(e_dv));
      chk("stall_f",  k, 32'(stall_f[k]),  32'(if_req[k] && !e_ifv && !if_kill[k]));
      chk("stall_m",  k, 32'(stall_m[k]),  32'(d_req[k] && !e_dv));
      chk("mem_addr", k, mem_addr[k], m_addr[k]);
      if (m_wdk[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
      if (e_rd) chk("rdata", k, rdata[k], mmem[k][m_addr[k][9:2]]);
      seen_ifv[k]    = if_valid[k];
      seen_dv[k]     = d_valid[k];
      seen_rdata[k]  = rdata[k];
      if (mem_en[k]) en_seen[k]++;
      last_ifdone[k] = e_ifv;
      last_ddone[k]  = e_dv;
      if (!reset) begin
        m_busy[k] = 0; m_kill[k] = 0; m_strk[k] = 0; m_we[k] = 0;
        m_addr[k] = '0; m_wdata[k] = '0; m_wdk[k] = 1;
      end else if (m_busy[k]) begin
        if (e_done) begin
          if (m_own_d[k] && m_we[k]) mmem[k][m_addr[k][9:2]] = m_wdata[k];
          m_busy[k] = 0;
          m_kill[k] = 0;
        end else begin
          if (!m_own_d[k] && if_kill[k]) m_kill[k] = 1;
          m_age[k]++;
        end
      end else begin
        fok    = if_req[k] && !if_kill[k];
        take_f = fok && ((m_strk[k] == ms_of(k)) || !d_req[k]);
        if (take_f) begin
          m_own_d[k] = 0; m_addr[k] = if_addr[k]; m_we[k] = 0;
          m_strk[k] = 0;  m_wdk[k] = 0;
        end else if (d_req[k]) begin
          m_own_d[k] = 1; m_addr[k] = d_addr[k]; m_we[k] = d_we[k];
          m_wdata[k] = d_wdata[k]; m_wdk[k] = 1;
          if (if_req[k]) m_strk[k] = (m_strk[k] + 1) % 16;
        end
        if (take_f || d_req[k]) begin
          m_busy[k] = 1; m_kill[k] = 0; m_age[k] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input bit want_d, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(want_d ? seen_dv[k] : seen_ifv[k]) && n < 16);
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      if_kill[k] = 1'b0;
      if (last_ifdone[k]) if_req[k] = 1'b0;
      else if (!if_req[k]) begin
        if (!(m_busy[k] && !m_own_d[k]) && $urandom_range(0, 2) == 0) begin
          if_req[k] = 1'b1; if_addr[k] = rnd_addr();
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_kill[k] = 1'b1; if_addr[k] = rnd_addr();
      end
      if (last_ddone[k]) d_req[k] = 1'b0;
      else if (!d_req[k]) begin
        if (!(m_busy[k] && m_own_d[k]) && $urandom_range(0, 2) == 0) begin
          d_req[k] = 1'b1; d_addr[k] = rnd_addr();
          d_we[k] = 1'($urandom_range(0, 1)); d_wdata[k] = $urandom;
        end
      end else if (m_busy[k] && m_own_d[k] && $urandom_range(0, 9) == 0) begin
        d_req[k] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr[k] = rnd_addr(); d_wdata[k] = $urandom;
      end
    end
    reset = ($urandom_range(0, 599) != 0);
  endtask

  initial begin
    int n;
    int en0;
    int nd;
    int nc;
    int guard;
    logic [6:0] order;
    for (int k = 0; k < 2; k++) begin
      if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      m_busy[k] = 0; m_own_d[k] = 0; m_kill[k] = 0; m_we[k] = 0; m_wdk[k] = 1;
      m_age[k] = 0; m_strk[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; en_seen[k] = 0;
      for (int i = 0; i < 256; i++) mmem[k][i] = init_word(8'(i));
    end
    if_req = '0; if_kill = '0; d_req = '0; d_we = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Lone fetch: valid in the (LAT+2)th cycle counting the request cycle.
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    wait_done(0, 0, n);
    chk("lone_fetch_cycles", 0, 32'(n), 32'(LAT0 + 2));
    chk("lone_fetch_rdata", 0, seen_rdata[0], init_word(8'h40));
    if_req[0] = 1'b0;

    // Both request: data write first, then the fetch, then read it back.
    if_req[0] = 1'b1; if_addr[0] = 32'h140;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200; d_wdata[0] = 32'hDEAD_BEEF;
    wait_done(0, 1, n);
    chk("simul_data_first", 0, 32'(n), 32'(LAT0 + 2));
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    wait_done(0, 0, n);
    chk("simul_fetch_next", 0, 32'(n), 32'(LAT0 + 2));
    if_req[0] = 1'b0;
    d_req[0] = 1'b1; d_addr[0] = 32'h200;
    wait_done(0, 1, n);
    chk("write_readback", 0, seen_rdata[0], 32'hDEAD_BEEF);
    d_req[0] = 1'b0;

    // Starvation guard: six held data accesses against a waiting fetch.
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0;
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    nd = 0; nc = 0; guard = 0; order = '0;
    while (nd < 6 && guard < 80) begin
      tick();
      guard++;
      if (seen_dv[0]) begin
        order = {order[5:0], 1'b1}; nc++; nd++;
        d_addr[0] = d_addr[0] + 32'd4;
        if (nd == 6) d_req[0] = 1'b0;
      end
      if (seen_ifv[0]) begin
        order = {order[5:0], 1'b0}; nc++;
        if_req[0] = 1'b0;
      end
    end
    chk("streak_data_count", 0, 32'(nd), 32'd6);
    chk("streak_order", 0, 32'(order), 32'(7'b1111011));
    chk("streak_total", 0, 32'(nc), 32'd7);
    d_req[0] = 1'b0; if_req[0] = 1'b0;

    // Kill during WAIT with a redirect: one suppressed, one served.
    en0 = en_seen[0];
    if_req[0] = 1'b1; if_addr[0] = 32'h180;
    tick();
    tick();
    if_kill[0] = 1'b1; if_addr[0] = 32'h1C0;
    tick();
    if_kill[0] = 1'b0;
    wait_done(0, 0, n);
    chk("kill_redirect_cycles", 0, 32'(n), 32'(LAT0 + 3));
    chk("kill_redirect_rdata", 0, seen_rdata[0], init_word(8'h70));
    chk("kill_mem_en_count", 0, 32'(en_seen[0] - en0), 32'd2);
    if_req[0] = 1'b0;

    // Reset in WAIT abandons the access.
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h240;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; d_req[0] = 1'b0;
    nd = 0;
    repeat (6) begin
      tick();
      if (seen_dv[0]) nd++;
    end
    chk("reset_no_valid", 0, 32'(nd), 32'd0);

    // LAT=1 instance: three-cycle accesses, back to back.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h300;
    wait_done(1, 1, n);
    chk("lat1_first_cycles", 1, 32'(n), 32'd3);
    chk("lat1_first_rdata", 1, seen_rdata[1], init_word(8'hC0));
    d_addr[1] = 32'h304;
    wait_done(1, 1, n);
    chk("lat1_b2b_cycles", 1, 32'(n), 32'd3);
    chk("lat1_b2b_rdata", 1, seen_rdata[1], init_word(8'hC1));
    d_req[1] = 1'b0;

    repeat (4000) begin
      tick();
      drive_random();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2: memory read/write latency in cycles from the mem_en cycle; legal range 1..15.
REQ-002 SHALL have parameter MAX_STREAK, default 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset=0 resets on the next rising clk).
REQ-005 SHALL have port if_req, input, 1 bit: fetch request, held high until if_valid.
REQ-006 SHALL have port if_addr, input, 32 bits: fetch address.
REQ-007 SHALL have port if_kill, input, 1 bit: fetch flush; discards the in-flight or pending fetch.
REQ-008 SHALL have port d_req, input, 1 bit: data request, held high until d_valid.
REQ-009 SHALL have port d_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port d_addr, input, 32 bits: data address.
REQ-011 SHALL have port d_wdata, input, 32 bits: data write value.
REQ-012 SHALL have port if_valid, output, 1 bit: one-cycle fetch completion.
REQ-013 SHALL have port d_valid, output, 1 bit: one-cycle data completion; acknowledges both reads and writes.
REQ-014 SHALL have port rdata, output, 32 bits: read data, meaningful only when if_valid or d_valid is high.
REQ-015 SHALL have port stall_f, output, 1 bit: fetch stall, equal to if_req & ~if_valid & ~if_kill.
REQ-016 SHALL have port stall_m, output, 1 bit: memory-stage stall, equal to d_req & ~d_valid.
REQ-017 SHALL have port mem_en, output, 1 bit: memory access strobe.
REQ-018 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-019 SHALL have port mem_addr, output, 32 bits: memory address.
REQ-020 SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-021 SHALL have port mem_rdata, input, 32 bits: memory read data, valid LAT cycles after the mem_en cycle.

Function
REQ-022 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-023 In IDLE with any request, SHALL register the owner, address, we and wdata, and go to ISSUE.
REQ-024 In IDLE with no request, SHALL stay in IDLE.
REQ-025 In ISSUE, SHALL drive mem_en=1 for exactly one cycle with the registered mem_addr, mem_we and mem_wdata, load the counter with LAT, and go to WAIT.
REQ-026 In WAIT, SHALL decrement the counter each cycle.
REQ-027 In the WAIT cycle where the counter equals 1 (the ISSUE+LAT cycle), SHALL pulse the owner's valid, drive rdata=mem_rdata, and return to IDLE.
REQ-028 Request-to-valid latency SHALL be LAT+2 cycles; no new grant is made in the completion cycle.
REQ-029 mem_we SHALL be 1 only for data writes; fetches are always reads.
REQ-030 Priority SHALL favour data over fetch when both request in IDLE.
REQ-031 A 4-bit streak counter SHALL increment on each data grant made while if_req is high and SHALL clear on any fetch grant.
REQ-032 When the streak counter equals MAX_STREAK and if_req is high, the fetch SHALL win the grant.
REQ-033 If if_kill is high in IDLE, SHALL not grant the fetch.
REQ-034 If if_kill is high in any cycle while a fetch is owned, SHALL set a kill flag; the access still completes on memory, but if_valid SHALL be suppressed and the kill flag cleared on return to IDLE.
REQ-035 if_kill SHALL have no effect on a data access.
REQ-036 A request dropped before completion SHALL not abort the access; valid still pulses.
REQ-037 Address and data inputs SHALL be sampled only at grant; later input changes SHALL be ignored.
REQ-038 if_valid and d_valid SHALL never be high in the same cycle.

Reset
REQ-039 On reset=0 at a clock edge, SHALL set state=IDLE, counter=0, streak=0, kill flag=0, and all registered address/data=0.
REQ-040 During and immediately after reset, SHALL hold mem_en=0, mem_we=0, if_valid=0 and d_valid=0.
REQ-041 Reset mid-access SHALL abandon the access with no valid pulse; the memory result is ignored.

Structure
REQ-042 SHALL place the state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2) and owner encoding (OWN_IF=1'b0, OWN_D=1'b1) in shared package mem_arb_pkg.
REQ-043 SHALL be a single module with no sub-modules; the memory model belongs in the testbench only.

Verification
REQ-044 Lone fetch: if_req=1, if_addr=0x100, LAT=2 -> mem_en one cycle later with mem_addr=0x100; if_valid 4 cycles after the request with rdata=memory[0x100]; stall_f high until then.
REQ-045 Simultaneous requests: if_req=1 and d_req=1 (write 0xDEADBEEF to 0x200) -> data granted first; d_valid, then a fetch grant in the next IDLE; memory[0x200]=0xDEADBEEF.
REQ-046 Starvation guard: d_req held high for 6 accesses with if_req=1, MAX_STREAK=4 -> 4 data completions, then 1 fetch completion, then the remaining data accesses.
REQ-047 Kill: fetch granted, if_kill pulsed in WAIT -> mem_en issued once, no if_valid, FSM back in IDLE after the LAT cycles, next fetch served normally.
REQ-048 Reset mid-access: reset=0 during WAIT -> next cycle IDLE, no valid pulse, mem_en=0.
REQ-049 LAT=1 boundary: read at 0x300 -> valid exactly 3 cycles after the request, back-to-back requests spaced 3 cycles apart.
